// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module      : y86_pkg
// Description : Shared Y86 definitions for the pipeline back end: register
//               ids, status codes, icodes, the W-register control struct with
//               its bubble value, and the status FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

  // Register ids
  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  // Processor status codes
  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  // Instruction codes
  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  // Control part of the W pipeline register. The data words (valE/valM)
  // are kept outside the struct because their width is a module parameter.
  typedef struct packed {
    logic       valid;
    logic [1:0] stat;
    logic [3:0] icode;
    logic [3:0] dstE;
    logic [3:0] dstM;
  } wCtl_t;

  localparam wCtl_t W_CTL_BUBBLE = '{
    valid: 1'b0,
    stat:  STAT_AOK,
    icode: ICODE_NOP,
    dstE:  RNONE,
    dstM:  RNONE
  };

  // Status FSM encoding
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } wbState_t;

  function automatic logic isFaultStat(input logic [1:0] stat);
    return (stat == STAT_ADR) || (stat == STAT_INS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_status_fsm.sv
`default_nettype none
// ============================================================================
// Module      : wb_status_fsm
// Description : RUN/HALT/FAULT processor status tracker for the write-back
//               stage. Leaves RUN when the instruction sitting in W carries
//               a non-AOK status; HALT and FAULT are terminal until reset.
//               The fault code (ADR or INS) is latched on entry to FAULT.
// Ports       : clk, rst_n      - clock, async active-low reset
//               wValid, wStat   - valid/status of the instruction in W
//               cpuStat         - architectural status (AOK/HLT/ADR/INS)
//               halted          - high whenever state is not RUN
//               running         - high while state is RUN
// Revision    : 1.0 - initial release
// ============================================================================
module wb_status_fsm
  import y86_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wValid,
  input  logic [1:0] wStat,
  output logic [1:0] cpuStat,
  output logic       halted,
  output logic       running
);

  wbState_t   r_state;
  wbState_t   w_stateNext;
  logic [1:0] r_faultCode;
  logic [1:0] w_faultCodeNext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_faultCode <= STAT_AOK;
    end else begin
      r_state     <= w_stateNext;
      r_faultCode <= w_faultCodeNext;
    end
  end

  always_comb begin
    w_stateNext     = r_state;
    w_faultCodeNext = r_faultCode;
    cpuStat         = STAT_AOK;
    halted          = 1'b1;
    running         = 1'b0;
    case (r_state)
      ST_RUN: begin
        halted  = 1'b0;
        running = 1'b1;
        if (wValid && (wStat == STAT_HLT)) begin
          w_stateNext = ST_HALT;
        end else if (wValid && isFaultStat(wStat)) begin
          w_stateNext     = ST_FAULT;
          w_faultCodeNext = wStat;
        end
      end
      ST_HALT: begin
        cpuStat = STAT_HLT;
      end
      ST_FAULT: begin
        cpuStat = r_faultCode;
      end
      default: begin
        // Unreachable encoding: report as an instruction fault and stay put.
        cpuStat = STAT_INS;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : Y86 pipeline write-back stage. Holds the W pipeline register
//               loaded from the memory stage, drives the register-file write
//               ports (also used by decode as W-stage forwarding sources),
//               and tracks processor status, freezing retirement on halt or
//               fault.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               m_valid..m_valM            - instruction from memory stage
//               w_stall, w_bubble          - W register hold / bubble insert
//               rf_dstE/valE, rf_dstM/valM - register-file write ports
//               w_stat                     - status of instruction in W
//               cpu_stat, halted           - architectural status
//               retired_cnt                - retired-instruction counter
// Config      : WB_RETIRE_CNT_EN - when defined, retired_cnt counts retired
//               instructions (saturating); otherwise it is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage
  import y86_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_valid,
  input  logic [1:0]        m_stat,
  input  logic [3:0]        m_icode,
  input  logic [3:0]        m_dstE,
  input  logic [DATA_W-1:0] m_valE,
  input  logic [3:0]        m_dstM,
  input  logic [DATA_W-1:0] m_valM,
  input  logic              w_stall,
  input  logic              w_bubble,
  output logic [3:0]        rf_dstE,
  output logic [DATA_W-1:0] rf_valE,
  output logic [3:0]        rf_dstM,
  output logic [DATA_W-1:0] rf_valM,
  output logic [1:0]        w_stat,
  output logic [1:0]        cpu_stat,
  output logic              halted,
  output logic [CNT_W-1:0]  retired_cnt
);

  wCtl_t             r_wCtl;
  logic [DATA_W-1:0] r_valE;
  logic [DATA_W-1:0] r_valM;

  logic w_running;
  logic w_hold;
  logic w_wrOk;
  logic w_unusedIcode;

  // Bubble outranks stall; a stopped processor freezes W entirely.
  assign w_hold = !w_running || (w_stall && !w_bubble);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wCtl <= W_CTL_BUBBLE;
      r_valE <= '0;
      r_valM <= '0;
    end else if (!w_hold) begin
      if (w_bubble) begin
        r_wCtl <= W_CTL_BUBBLE;
        r_valE <= '0;
        r_valM <= '0;
      end else begin
        r_wCtl.valid <= m_valid;
        r_wCtl.stat  <= m_stat;
        r_wCtl.icode <= m_icode;
        r_wCtl.dstE  <= m_dstE;
        r_wCtl.dstM  <= m_dstM;
        r_valE       <= m_valE;
        r_valM       <= m_valM;
      end
    end
  end

  wb_status_fsm u_statusFsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .wValid  (r_wCtl.valid),
    .wStat   (r_wCtl.stat),
    .cpuStat (cpu_stat),
    .halted  (halted),
    .running (w_running)
  );

  // The instruction that moves the FSM out of RUN has a non-AOK status, so
  // it is excluded here without any extra term.
  assign w_wrOk = r_wCtl.valid && (r_wCtl.stat == STAT_AOK) && w_running;

  // When both ports target the same register (popq %rsp) the loaded value
  // on the M port must win, so the E write is dropped.
  always_comb begin
    rf_dstM = RNONE;
    rf_dstE = RNONE;
    if (w_wrOk) begin
      rf_dstM = r_wCtl.dstM;
      if (!((r_wCtl.dstE == r_wCtl.dstM) && (r_wCtl.dstM != RNONE))) begin
        rf_dstE = r_wCtl.dstE;
      end
    end
  end

  assign rf_valE = r_valE;
  assign rf_valM = r_valM;
  assign w_stat  = r_wCtl.valid ? r_wCtl.stat : STAT_AOK;

  // icode travels with the instruction for debug visibility only.
  assign w_unusedIcode = ^r_wCtl.icode;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] r_retiredCnt;

  // A stalled instruction is counted only on the edge where it leaves W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retiredCnt <= '0;
    end else if (w_wrOk && !w_hold && (r_retiredCnt != {CNT_W{1'b1}})) begin
      r_retiredCnt <= r_retiredCnt + CNT_W'(1);
    end
  end

  assign retired_cnt = r_retiredCnt;
`else
  assign retired_cnt = '0;
`endif

endmodule
`default_nettype wire
